// File: rtl/seg7_digit_decoder.sv
// seg7_digit_decoder
//   Registered 4-bit digit code to 7-segment decoder for one clock-display digit.
//   It sits between the time-keeping counters and the display multiplexer.
//   Segment lines CA..CG map to segments a..g. CA is the top segment and CG is the middle one.
//   The priority order is lamp_test, then blank, then the decode table.
//   Every output comes straight from a flop.
//   Optional build macro SEG7_HEX_EN: codes 10..15 show the hex glyphs A b C d E F.
//   When SEG7_HEX_EN is undefined, codes 10..15 blank the digit.
//   ACTIVE_LOW=1 suits common-anode boards, where a lit segment drives 0.

module seg7_digit_decoder #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       blank,
   input  logic       lamp_test,
   input  logic [3:0] in,
   output logic       CA,
   output logic       CB,
   output logic       CC,
   output logic       CD,
   output logic       CE,
   output logic       CF,
   output logic       CG
);

   // Segment vectors are ordered {a,b,c,d,e,f,g}. A 1 in w_lit means the segment is lit.
   localparam logic [6:0] SEG_OFF = 7'b000_0000;
   localparam logic [6:0] SEG_ALL = 7'b111_1111;

   logic [6:0] w_lit;
   logic [6:0] w_sel;
   logic [6:0] w_drive;
   logic [6:0] r_seg;

   // Decode the digit code into a lit-segment pattern. This pattern is independent of polarity.
   always_comb begin
      w_lit = SEG_OFF;
      case (in)
         4'd0:    w_lit = 7'b111_1110;
         4'd1:    w_lit = 7'b011_0000;
         4'd2:    w_lit = 7'b110_1101;
         4'd3:    w_lit = 7'b111_1001;
         4'd4:    w_lit = 7'b011_0011;
         4'd5:    w_lit = 7'b101_1011;
         4'd6:    w_lit = 7'b101_1111;
         4'd7:    w_lit = 7'b111_0000;
         4'd8:    w_lit = 7'b111_1111;
         4'd9:    w_lit = 7'b111_1011;
`ifdef SEG7_HEX_EN
         4'd10:   w_lit = 7'b111_0111;
         4'd11:   w_lit = 7'b001_1111;
         4'd12:   w_lit = 7'b100_1110;
         4'd13:   w_lit = 7'b011_1101;
         4'd14:   w_lit = 7'b100_1111;
         4'd15:   w_lit = 7'b100_0111;
`endif
         default: w_lit = SEG_OFF;
      endcase
   end

   // Apply the override priority: lamp test first, then blanking, then the decoded glyph.
   always_comb begin
      w_sel = w_lit;
      if (lamp_test)
         w_sel = SEG_ALL;
      else if (blank)
         w_sel = SEG_OFF;
   end

   // Convert the lit pattern to board polarity before the flops, so the outputs carry no logic.
   assign w_drive = w_sel ^ {7{ACTIVE_LOW}};

   // Segment register. Reset turns every segment off at once. en=0 holds the last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_seg <= {7{ACTIVE_LOW}};
      else if (en)
         r_seg <= w_drive;
   end

   assign {CA, CB, CC, CD, CE, CF, CG} = r_seg;

endmodule

// File: tb/tb_seg7_digit_decoder.sv
// Directed bench for seg7_digit_decoder.
// The main DUT uses ACTIVE_LOW=1. A second DUT with ACTIVE_LOW=0 shares the same stimulus.
// Segment vectors are ordered {CA,CB,CC,CD,CE,CF,CG}.

module tb_seg7_digit_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       blank;
   logic       lamp_test;
   logic [3:0] in;

   logic       l_ca, l_cb, l_cc, l_cd, l_ce, l_cf, l_cg;
   logic       h_ca, h_cb, h_cc, h_cd, h_ce, h_cf, h_cg;
   logic [6:0] seg_lo;
   logic [6:0] seg_hi;

   int checks = 0;
   int errors = 0;

   logic [6:0] exp_tab [0:9];

   always #5 clk = ~clk;

   seg7_digit_decoder #(.ACTIVE_LOW(1'b1)) u_dut_al (
      .clk(clk), .rst(rst), .en(en), .blank(blank), .lamp_test(lamp_test), .in(in),
      .CA(l_ca), .CB(l_cb), .CC(l_cc), .CD(l_cd), .CE(l_ce), .CF(l_cf), .CG(l_cg)
   );

   seg7_digit_decoder #(.ACTIVE_LOW(1'b0)) u_dut_ah (
      .clk(clk), .rst(rst), .en(en), .blank(blank), .lamp_test(lamp_test), .in(in),
      .CA(h_ca), .CB(h_cb), .CC(h_cc), .CD(h_cd), .CE(h_ce), .CF(h_cf), .CG(h_cg)
   );

   assign seg_lo = {l_ca, l_cb, l_cc, l_cd, l_ce, l_cf, l_cg};
   assign seg_hi = {h_ca, h_cb, h_cc, h_cd, h_ce, h_cf, h_cg};

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_tab[0] = 7'b0000001; exp_tab[1] = 7'b1001111; exp_tab[2] = 7'b0010010;
      exp_tab[3] = 7'b0000110; exp_tab[4] = 7'b1001100; exp_tab[5] = 7'b0100100;
      exp_tab[6] = 7'b0100000; exp_tab[7] = 7'b0001111; exp_tab[8] = 7'b0000000;
      exp_tab[9] = 7'b0000100;

      rst = 1'b1; en = 1'b1; blank = 1'b0; lamp_test = 1'b0; in = 4'd8;
      #2;
      chk("reset_al", seg_lo, 7'b1111111);
      chk("reset_ah", seg_hi, 7'b0000000);
      tick();
      chk("reset_held", seg_lo, 7'b1111111);
      rst = 1'b0;
      tick();
      chk("first_8", seg_lo, 7'b0000000);
      chk("first_8_ah", seg_hi, 7'b1111111);

      // Asynchronous reset in mid-cycle, well away from any clock edge.
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_al", seg_lo, 7'b1111111);
      chk("async_rst_ah", seg_hi, 7'b0000000);
      #1;
      rst = 1'b0;
      tick();
      chk("post_rst_8", seg_lo, 7'b0000000);

      // Sweep the decimal codes.
      for (int i = 0; i < 10; i++) begin
         in = 4'(i);
         tick();
         chk($sformatf("dec_%0d", i), seg_lo, exp_tab[i]);
      end

      // Apply the ACTIVE_LOW=0 polarity with in=1.
      in = 4'd1;
      tick();
      chk("ah_in1", seg_hi, 7'b0110000);

      // Check codes 10..15.
      in = 4'd10;
      tick();
`ifdef SEG7_HEX_EN
      chk("hex_A", seg_lo, 7'b0001000);
`else
      chk("code10_blank", seg_lo, 7'b1111111);
`endif
      in = 4'd12;
      tick();
`ifdef SEG7_HEX_EN
      chk("hex_C", seg_lo, 7'b0110001);
`else
      chk("code12_blank", seg_lo, 7'b1111111);
`endif
      in = 4'd15;
      tick();
`ifdef SEG7_HEX_EN
      chk("hex_F", seg_lo, 7'b0111000);
`else
      chk("code15_blank", seg_lo, 7'b1111111);
`endif

      // Check the override priority.
      in = 4'd3;
      tick();
      chk("prio_3", seg_lo, 7'b0000110);
      lamp_test = 1'b1; blank = 1'b1;
      tick();
      chk("prio_lt_blank", seg_lo, 7'b0000000);
      lamp_test = 1'b0;
      tick();
      chk("prio_blank", seg_lo, 7'b1111111);
      chk("prio_blank_ah", seg_hi, 7'b0000000);
      blank = 1'b0;
      tick();
      chk("prio_release", seg_lo, 7'b0000110);

      // Check that en=0 holds the outputs.
      in = 4'd5;
      tick();
      chk("hold_5", seg_lo, 7'b0100100);
      en = 1'b0; in = 4'd1;
      tick();
      chk("hold_in", seg_lo, 7'b0100100);
      lamp_test = 1'b1;
      tick();
      chk("hold_lt", seg_lo, 7'b0100100);
      lamp_test = 1'b0; blank = 1'b1;
      tick();
      chk("hold_blank", seg_lo, 7'b0100100);
      blank = 1'b0; en = 1'b1;
      tick();
      chk("resume_1", seg_lo, 7'b1001111);
      chk("resume_1_ah", seg_hi, 7'b0110000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
